// File: rtl/obi_sram_ctrl.sv
// obi_sram_ctrl: OBI slave bridging one outstanding transaction onto a single-port SRAM macro
// Ports: clk_i/wb_rst_i clock and sync active-high reset; req_i/gnt_o/addr_i/we_i/be_i/wdata_i OBI request;
// rvalid_o/rdata_o/err_o OBI response; sram_* active-low macro controls, word address, data in/out.
module obi_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int SRAM_AW = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic clk_i,
  input  logic wb_rst_i,
  input  logic req_i,
  output logic gnt_o,
  input  logic [31:0] addr_i,
  input  logic we_i,
  input  logic [3:0] be_i,
  input  logic [31:0] wdata_i,
  output logic rvalid_o,
  output logic [31:0] rdata_o,
  output logic err_o,
  output logic sram_csb_o,
  output logic sram_web_o,
  output logic [3:0] sram_wmask_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0] sram_din_o,
  input  logic [31:0] sram_dout_i
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic is_read, is_read_n, oor, oor_n;
  logic in_range, accept, sel;
  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];
  assign in_range = addr_i[31:SRAM_AW+2] == BASE_ADDR[31:SRAM_AW+2];
  assign gnt_o = !wb_rst_i && req_i && state != RD_WAIT;
  assign accept = req_i && gnt_o;
  // out-of-range accesses and empty-mask writes never touch the macro
  assign sel = accept && in_range && (!we_i || be_i != 4'b0);
  assign sram_csb_o = !sel;
  assign sram_web_o = sel ? !we_i : 1'b1;
  assign sram_wmask_o = be_i;
  assign sram_addr_o = addr_i[SRAM_AW+1:2];
  assign sram_din_o = wdata_i;
  assign rvalid_o = !wb_rst_i && state == RESP;
  assign err_o = rvalid_o && oor;
  assign rdata_o = rvalid_o && is_read && !oor ? sram_dout_i : 32'h0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    is_read_n = is_read;
    oor_n = oor;
    if (state == RD_WAIT) begin
      cnt_n = cnt - 3'd1;
      state_n = cnt == 3'd1 ? RESP : RD_WAIT;
    end else if (accept) begin
      is_read_n = !we_i;
      oor_n = !in_range;
      state_n = we_i || READ_LATENCY == 1 ? RESP : RD_WAIT;
      cnt_n = we_i ? 3'd0 : 3'(READ_LATENCY - 1);
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= 3'd0;
      is_read <= 1'b0;
      oor <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      is_read <= is_read_n;
      oor <= oor_n;
    end
  end
endmodule

// File: doc/obi_sram_ctrl.md
OBI_SRAM_CTRL -- requirements
Module: obi_sram_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, byte base address of the SRAM window.
REQ-002 SHALL have parameter SRAM_AW, default 8, SRAM word-address width (2^SRAM_AW 32-bit words).
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal 1..4, cycles from macro select to valid sram_dout_i.
REQ-004 SHALL have ports: clk_i input 1, the single clock; all logic on posedge.
REQ-005 SHALL have wb_rst_i input 1, reset, synchronous, active-high.
REQ-006 SHALL have req_i input 1, OBI request.
REQ-007 SHALL have gnt_o output 1, OBI grant.
REQ-008 SHALL have addr_i input 32, OBI byte address.
REQ-009 SHALL have we_i input 1, 1=write.
REQ-010 SHALL have be_i input 4, byte enables.
REQ-011 SHALL have wdata_i input 32, write data.
REQ-012 SHALL have rvalid_o output 1, OBI response valid.
REQ-013 SHALL have rdata_o output 32, read data.
REQ-014 SHALL have err_o output 1, response error flag, qualified by rvalid_o.
REQ-015 SHALL have sram_csb_o output 1, macro chip select, active-low.
REQ-016 SHALL have sram_web_o output 1, macro write enable, active-low.
REQ-017 SHALL have sram_wmask_o output 4, byte write mask.
REQ-018 SHALL have sram_addr_o output SRAM_AW, word address.
REQ-019 SHALL have sram_din_o output 32, write data.
REQ-020 SHALL have sram_dout_i input 32, read data.

Function
REQ-021 SHALL treat a transaction as accepted in any cycle with req_i && gnt_o (accept cycle T).
REQ-022 SHALL decode in-range as addr_i[31:SRAM_AW+2] == BASE_ADDR[31:SRAM_AW+2]; word index addr_i[SRAM_AW+1:2]; addr_i[1:0] ignored.
REQ-023 SHALL implement FSM IDLE, RD_WAIT, RESP; single outstanding transaction.
REQ-024 SHALL assert gnt_o = req_i in IDLE and in RESP; gnt_o = 0 in RD_WAIT.
REQ-025 SHALL, on accept cycle only, drive sram_csb_o=0 combinationally for in-range reads and in-range writes with be_i!=0; otherwise sram_csb_o=1.
REQ-026 SHALL drive sram_web_o=!we_i, sram_wmask_o=be_i, sram_addr_o=word index, sram_din_o=wdata_i on accept; sram_web_o=1 when not selecting.
REQ-027 SHALL, for writes (any range/be), go to RESP and assert rvalid_o exactly at T+1.
REQ-028 SHALL, for reads, assert rvalid_o exactly at T+READ_LATENCY; READ_LATENCY=1 goes directly to RESP, else RD_WAIT with down-counter loaded READ_LATENCY-1.
REQ-029 SHALL leave RD_WAIT to RESP when counter reaches 1 (counter decrements each cycle).
REQ-030 SHALL assert rvalid_o only in RESP, for exactly one cycle per accepted transaction.
REQ-031 SHALL, in RESP, accept a new request (back-to-back) and transition as from IDLE; without req_i return to IDLE.
REQ-032 SHALL drive rdata_o = sram_dout_i when rvalid_o for an in-range read; 32'h0 in all other cycles/cases.
REQ-033 SHALL assert err_o with rvalid_o for out-of-range transactions; err_o=0 otherwise; out-of-range writes never reach the macro.
REQ-034 SHALL register per-transaction flags (is_read, out_of_range) at accept; response SHALL NOT depend on inputs after T except sram_dout_i.
REQ-035 SHALL treat in-range write with be_i=4'b0 as no-op, rvalid at T+1, err_o=0.

Reset
REQ-036 SHALL, while wb_rst_i=1, force state IDLE, counter 0, rvalid_o=0, err_o=0, rdata_o=0, gnt_o=0, sram_csb_o=1, sram_web_o=1.
REQ-037 SHALL drop any pending response on reset mid-transaction; no rvalid_o after reset deasserts without a new accept.
REQ-038 SHALL grant in the first cycle after reset deassertion if req_i=1.

Verification
REQ-039 Write 0xA5A5_5A5A, be=4'hF, addr=BASE+0x10 -> csb=0, web=0, sram_addr=4 at T; rvalid=1, err=0 at T+1.
REQ-040 READ_LATENCY=3, read BASE+0x10, macro returns 0xA5A5_5A5A -> gnt low T+1,T+2; rvalid=1, rdata=0xA5A5_5A5A at T+3.
REQ-041 Read 0x4000_0000 (out-of-range) -> csb stays 1; rvalid=1, err=1, rdata=0 at T+READ_LATENCY.
REQ-042 READ_LATENCY=1, req held with 4 reads -> grants every cycle, 4 rvalid pulses, one per cycle, in order.
REQ-043 Write be=4'b0010 -> sram_wmask=4'b0010; write be=0 -> csb=1, rvalid at T+1, err=0.
REQ-044 READ_LATENCY=4, reset asserted at T+2 of a read -> no rvalid at T+4 or after; outputs at reset values.
